s2p_rx_fifo: RTL and testbench
==============================

Name: s2p_rx_fifo

Overview:
- Receive end of the team's bit-serial nibble link (data/vld pair driven by the p2s transmitter).
- Deserializes each nibble, buffers completed nibbles in a small FIFO, and presents them to a downstream consumer through a read-enable handshake.
- Detects aborted (partial) nibbles and FIFO overflow so link errors are visible instead of silently corrupting data.

Parameters:
- WIDTH, 4, bits per serial word (nibble size)
- DEPTH, 4, FIFO entries; power of two, minimum 2
- ERR_W, 8, width of the saturating frame-error counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- data  input  1  serial bit, sampled only when vld=1
- vld  input  1  bit-valid strobe; WIDTH consecutive vld=1 cycles form one word, MSB first
- rd_en  input  1  consumer pops head word this cycle
- clr_ovf  input  1  clears sticky overflow flag
- dout  output  WIDTH  FIFO head word (first-word-fall-through)
- empty  output  1  FIFO holds no words
- full  output  1  FIFO holds DEPTH words
- level  output  clog2(DEPTH)+1  current word count
- ovf  output  1  sticky: a completed word was dropped because the FIFO was full
- err_cnt  output  ERR_W  saturating count of aborted words

Behaviour:
- Interface decision: one clock, clk; reset n_rst is asynchronous, active-low.
- Reset values: dout=0, empty=1, full=0, level=0, ovf=0, err_cnt=0; bit counter=0, shift register=0, FSM=IDLE, FIFO pointers=0.
- FSM states: IDLE (no partial word), SHIFT (1..WIDTH-1 bits captured).
  - IDLE, vld=1: shift in data, bit_cnt=1, go to SHIFT. (WIDTH=1 degenerate case not supported.)
  - SHIFT, vld=1: shift in data (shreg <= {shreg[WIDTH-2:0], data}), bit_cnt+1.
  - On the WIDTH-th bit, the assembled word {shreg, data} pushes in the same cycle; bit_cnt=0, return to IDLE.
  - SHIFT, vld=0: frame abort. Discard partial word, bit_cnt=0, go to IDLE, err_cnt+1 (saturates at all-ones).
  - Back-to-back words with no vld gap are legal.
- Latency: the word appears on dout with empty=0 on the clock edge after its last bit is sampled (1 cycle).
- Push rules:
  - Word completes while not full: write at wr_ptr, wr_ptr+1 mod DEPTH.
  - Word completes while full and rd_en=0: word dropped, ovf <= 1.
  - Word completes while full and rd_en=1: pop and push both accepted; level unchanged; no overflow.
- Pop rules:
  - rd_en=1 and empty=0: rd_ptr+1 mod DEPTH, level-1.
  - rd_en while empty: ignored, no state change, no error.
  - dout = mem[rd_ptr] while not empty; holds 0 when empty.
- Simultaneous push and pop while not full/empty: level unchanged, both pointers advance.
- ovf: set by a dropped word, cleared by clr_ovf. If both occur in the same cycle, set wins.
- full = (level==DEPTH); empty = (level==0). Pointers wrap by modulo arithmetic, with no separate wrap bit; level is the authority.
- Reset asserted mid-word or with a non-empty FIFO: all contents and the partial word are lost; outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package/header holds: WIDTH default, FSM state encodings (ST_IDLE, ST_SHIFT), and a clog2 constant function.
- Natural sub-module: nib_fifo, a synchronous FWFT FIFO with ports push, wdata, pop, rdata, empty, full, level, parameterized WIDTH/DEPTH.
- s2p_rx_fifo keeps the FSM, shift register, error counter and overflow flag.

Test Plan:
- Single word: vld=1 for 4 cycles with data 1,0,1,1 -> next cycle empty=0, dout=4'hB, level=1. rd_en 1 cycle -> empty=1, level=0.
- Back-to-back: bits for 4'hA, 4'h5, 4'h3 sent contiguously -> three pops return A, 5, 3 in order, err_cnt=0.
- Abort: vld=1 for 2 bits, then vld=0, then a full 4'hC -> err_cnt=1, FIFO holds only C.
- Overflow: 5 words (1,2,3,4,5) with no reads -> full=1, ovf=1, pops yield 1,2,3,4. Pulse clr_ovf -> ovf=0.
- Full plus simultaneous pop: FIFO full with 1..4, 5th word completes with rd_en=1 that cycle -> ovf=0, level=4, pops yield 2,3,4,5.
- Reset mid-operation: after 2 stored words and 2 bits of a third, pull n_rst low -> all outputs at reset values without a clock edge. After release, a fresh 4'h9 is received correctly.

Source files
------------

// File: rtl/s2p_rx_fifo_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the serial nibble receiver.
package s2p_rx_fifo_pkg;

   localparam int NIB_WIDTH = 32'sd4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < n) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/s2p_rx_fifo_nib_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word, flags and level are all registered.
module nib_fifo
   import s2p_rx_fifo_pkg::*;
#(
   parameter int WIDTH = NIB_WIDTH,
   parameter int DEPTH = 32'sd4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rdata,
   output logic                    empty,
   output logic                    full,
   output logic [clog2(DEPTH):0]   level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 32'sd1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    rd_ptr_nxt_s;
   logic [LW-1:0]    level_nxt_s;
   logic [WIDTH-1:0] rdata_nxt_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Accept/level bookkeeping and next head word; a push into the new head slot bypasses memory.
   always_comb begin
      do_pop_s     = pop & (level != {LW{1'b0}});
      do_push_s    = push & ((level != LW'(DEPTH)) | do_pop_s);
      rd_ptr_nxt_s = do_pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
      case ({do_push_s, do_pop_s})
         2'b10:   level_nxt_s = level + LW'(1'b1);
         2'b01:   level_nxt_s = level - LW'(1'b1);
         default: level_nxt_s = level;
      endcase
      if (level_nxt_s == {LW{1'b0}}) begin
         rdata_nxt_s = {WIDTH{1'b0}};
      end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         rdata_nxt_s = wdata;
      end else begin
         rdata_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage, pointers and registered status outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level    <= {LW{1'b0}};
         empty    <= 1'b1;
         full     <= 1'b0;
         rdata    <= {WIDTH{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         level    <= level_nxt_s;
         empty    <= (level_nxt_s == {LW{1'b0}});
         full     <= (level_nxt_s == LW'(DEPTH));
         rdata    <= rdata_nxt_s;
      end
   end

endmodule

// File: rtl/s2p_rx_fifo.sv
// Bit-serial nibble receiver: deserializes MSB-first words, counts aborted frames and
// flags words lost to a full FIFO.
module s2p_rx_fifo
   import s2p_rx_fifo_pkg::*;
#(
   parameter int WIDTH = NIB_WIDTH,
   parameter int DEPTH = 32'sd4,
   parameter int ERR_W = 32'sd8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    data,
   input  logic                    vld,
   input  logic                    rd_en,
   input  logic                    clr_ovf,
   output logic [WIDTH-1:0]        dout,
   output logic                    empty,
   output logic                    full,
   output logic [clog2(DEPTH):0]   level,
   output logic                    ovf,
   output logic [ERR_W-1:0]        err_cnt
);

   localparam int CW = clog2(WIDTH);

   rx_state_e        state_r;
   logic [CW-1:0]    bit_cnt_r;
   logic [WIDTH-2:0] shreg_r;
   logic [WIDTH-1:0] word_s;
   logic             word_done_s;
   logic             drop_s;

   // A word completes on its last bit; it is lost only if the FIFO is full and nothing pops.
   always_comb begin
      word_s      = {shreg_r, data};
      word_done_s = (state_r == ST_SHIFT) && vld && (bit_cnt_r == CW'(WIDTH - 1));
      drop_s      = word_done_s && full && !rd_en;
   end

   // Deserializer FSM with abort counting and the sticky overflow flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= {CW{1'b0}};
         shreg_r   <= {(WIDTH-1){1'b0}};
         err_cnt   <= {ERR_W{1'b0}};
         ovf       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (vld) begin
                  shreg_r   <= word_s[WIDTH-2:0];
                  bit_cnt_r <= CW'(1'b1);
                  state_r   <= ST_SHIFT;
               end else begin
                  bit_cnt_r <= {CW{1'b0}};
               end
            end
            ST_SHIFT: begin
               if (word_done_s) begin
                  shreg_r   <= {(WIDTH-1){1'b0}};
                  bit_cnt_r <= {CW{1'b0}};
                  state_r   <= ST_IDLE;
               end else if (vld) begin
                  shreg_r   <= word_s[WIDTH-2:0];
                  bit_cnt_r <= bit_cnt_r + CW'(1'b1);
               end else begin
                  shreg_r   <= {(WIDTH-1){1'b0}};
                  bit_cnt_r <= {CW{1'b0}};
                  state_r   <= ST_IDLE;
                  if (err_cnt != {ERR_W{1'b1}}) begin
                     err_cnt <= err_cnt + ERR_W'(1'b1);
                  end
               end
            end
            default: begin
               shreg_r   <= {(WIDTH-1){1'b0}};
               bit_cnt_r <= {CW{1'b0}};
               state_r   <= ST_IDLE;
            end
         endcase
         if (drop_s) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

   nib_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (word_done_s),
      .wdata (word_s),
      .pop   (rd_en),
      .rdata (dout),
      .empty (empty),
      .full  (full),
      .level (level)
   );

endmodule

// File: tb/tb_s2p_rx_fifo.sv
// Directed and randomized bench for s2p_rx_fifo against a queue-based reference model.
module tb_s2p_rx_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int ERR_W = 8;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             data = 1'b0;
   logic             vld = 1'b0;
   logic             rd_en = 1'b0;
   logic             clr_ovf = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic [2:0]       level;
   logic             ovf;
   logic [ERR_W-1:0] err_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int q[$];
   int nbits = 0;
   int pbits = 0;
   int errm  = 0;
   bit ovfm  = 1'b0;

   always #5 clk = ~clk;

   s2p_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
      .clk(clk), .n_rst(n_rst), .data(data), .vld(vld), .rd_en(rd_en),
      .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full),
      .level(level), .ovf(ovf), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, ".dout"},    dout,    (sz > 0) ? q[0] : 0);
      chk({tag, ".empty"},   empty,   (sz == 0) ? 1 : 0);
      chk({tag, ".full"},    full,    (sz == DEPTH) ? 1 : 0);
      chk({tag, ".level"},   level,   sz);
      chk({tag, ".ovf"},     ovf,     ovfm);
      chk({tag, ".err_cnt"}, err_cnt, errm);
   endtask

   task automatic model_reset();
      q.delete();
      nbits = 0;
      pbits = 0;
      errm  = 0;
      ovfm  = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, then check #1 after the edge.
   task automatic cycle(input string tag, input logic d, input logic v, input logic r, input logic c);
      int  sz;
      bit  pop;
      bit  done;
      bit  dropped;
      data = d; vld = v; rd_en = r; clr_ovf = c;
      sz      = q.size();
      pop     = r && (sz > 0);
      done    = v && (nbits == WIDTH - 1);
      dropped = 1'b0;
      if (pop) q.delete(0);
      if (done) begin
         if (sz < DEPTH || pop) q.push_back(((pbits * 2) + int'(d)) % (1 << WIDTH));
         else dropped = 1'b1;
         nbits = 0;
         pbits = 0;
      end else if (v) begin
         pbits = (pbits * 2) + int'(d);
         nbits++;
      end else begin
         if (nbits > 0 && errm < (1 << ERR_W) - 1) errm++;
         nbits = 0;
         pbits = 0;
      end
      if (dropped) ovfm = 1'b1;
      else if (c) ovfm = 1'b0;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input string tag, input int w, input logic rd_last);
      logic [WIDTH-1:0] wb;
      wb = WIDTH'(w);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         cycle(tag, wb[i], 1'b1, (i == 0) ? rd_last : 1'b0, 1'b0);
      end
   endtask

   task automatic idle(input string tag, input logic r, input logic c);
      cycle(tag, 1'b0, 1'b0, r, c);
   endtask

   initial begin
      #22;
      chk("rst.dout", dout, 0);
      chk("rst.empty", empty, 1);
      chk("rst.level", level, 0);
      check_all("rst");
      @(negedge clk);
      n_rst = 1'b1;

      // single word 1011
      send_word("single", 4'hB, 1'b0);
      chk("single.lit_dout", dout, 4'hB);
      chk("single.lit_level", level, 1);
      idle("single_pop", 1'b1, 1'b0);
      chk("single.lit_empty", empty, 1);

      // back-to-back A,5,3
      send_word("b2b", 4'hA, 1'b0);
      send_word("b2b", 4'h5, 1'b0);
      send_word("b2b", 4'h3, 1'b0);
      chk("b2b.lit_level", level, 3);
      chk("b2b.lit_head", dout, 4'hA);
      for (int k = 0; k < 3; k++) idle("b2b_pop", 1'b1, 1'b0);
      chk("b2b.lit_err", err_cnt, 0);

      // abort after 2 bits, then C
      cycle("abort", 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("abort", 1'b0, 1'b1, 1'b0, 1'b0);
      idle("abort", 1'b0, 1'b0);
      send_word("abort", 4'hC, 1'b0);
      chk("abort.lit_err", err_cnt, 1);
      chk("abort.lit_dout", dout, 4'hC);
      chk("abort.lit_level", level, 1);
      idle("abort_pop", 1'b1, 1'b0);

      // overflow: 1..5 without reads
      for (int k = 1; k <= 5; k++) send_word("ovf", k, 1'b0);
      chk("ovf.lit_full", full, 1);
      chk("ovf.lit_ovf", ovf, 1);
      idle("ovf_clr", 1'b0, 1'b1);
      chk("ovf.lit_clr", ovf, 0);
      for (int k = 1; k <= 4; k++) begin
         chk("ovf.lit_pop", dout, k);
         idle("ovf_pop", 1'b1, 1'b0);
      end

      // full plus simultaneous pop on the completing bit
      for (int k = 1; k <= 4; k++) send_word("fullpop", k, 1'b0);
      send_word("fullpop", 5, 1'b1);
      chk("fullpop.lit_ovf", ovf, 0);
      chk("fullpop.lit_level", level, 4);
      for (int k = 2; k <= 5; k++) begin
         chk("fullpop.lit_pop", dout, k);
         idle("fullpop_pop", 1'b1, 1'b0);
      end

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         cycle("rand", 1'($urandom), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      end
      idle("rand_end", 1'b0, 1'b0);

      // reset mid-operation: 2 words + 2 bits, then async reset between edges
      send_word("midrst", 4'h6, 1'b0);
      send_word("midrst", 4'h7, 1'b0);
      cycle("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      n_rst = 1'b0;
      #1;
      chk("midrst.dout", dout, 0);
      chk("midrst.empty", empty, 1);
      chk("midrst.full", full, 0);
      chk("midrst.level", level, 0);
      chk("midrst.ovf", ovf, 0);
      chk("midrst.err_cnt", err_cnt, 0);
      model_reset();
      vld = 1'b0; data = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      send_word("after_rst", 4'h9, 1'b0);
      chk("after_rst.lit_dout", dout, 4'h9);
      chk("after_rst.lit_level", level, 1);
      idle("after_rst_pop", 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
